// File: rtl/key_action_gen.sv
// key_action_gen: turns the held keyboard keycode into game action events.
// Left/right use DAS + auto-repeat, soft drop repeats without delay, and
// rotate/hard drop fire once per press. Events go out on a one-deep
// valid/ready holding register; an event that cannot be held is reported
// on evt_drop.
module key_action_gen #(
    parameter int DAS_FRAMES  = 10,
    parameter int ARR_FRAMES  = 3,
    parameter int SOFT_FRAMES = 2,
    parameter int CNT_W       = 5
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       VGA_VS,
    input  logic [7:0] keycode,
    input  logic       enable,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic       evt_drop
);

    localparam logic [2:0] EV_NONE  = 3'd0;
    localparam logic [2:0] EV_LEFT  = 3'd1;
    localparam logic [2:0] EV_RIGHT = 3'd2;
    localparam logic [2:0] EV_ROT   = 3'd3;
    localparam logic [2:0] EV_SOFT  = 3'd4;
    localparam logic [2:0] EV_HARD  = 3'd5;

    localparam logic [CNT_W-1:0] DAS_LAST  = CNT_W'(DAS_FRAMES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST  = CNT_W'(ARR_FRAMES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, period_last;
    logic [2:0]       lkey, lkey_n;
    logic [2:0]       cur_code, gen_code;
    logic [7:0]       key_q;
    logic             vs_q;
    logic             armed;
    logic             frame_tick, press;

    // Keycode to action map; anything unmapped counts as no key.
    always_comb begin
        cur_code = EV_NONE;
        case (keycode)
            8'h50:   cur_code = EV_LEFT;
            8'h4F:   cur_code = EV_RIGHT;
            8'h52:   cur_code = EV_ROT;
            8'h51:   cur_code = EV_SOFT;
            8'h2C:   cur_code = EV_HARD;
            default: cur_code = EV_NONE;
        endcase
    end

    assign frame_tick = VGA_VS & ~vs_q;
    // armed is low for the first cycle after reset so a key held through
    // reset is seen by key_q before it could count as a press.
    assign press       = armed & enable & (cur_code != EV_NONE) & (keycode != key_q);
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign period_last = (lkey == EV_SOFT) ? SOFT_LAST : ARR_LAST;

    // Input history: keycode and VS tracked every cycle regardless of enable.
    always_ff @(posedge Clk) begin
        if (reset) begin
            key_q <= 8'h00;
            vs_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            key_q <= keycode;
            vs_q  <= VGA_VS;
            armed <= 1'b1;
        end
    end

    // Repeat FSM state register.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            lkey  <= EV_NONE;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            lkey  <= lkey_n;
        end
    end

    // Next state and generated event; a new press always restarts from IDLE rules.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        lkey_n   = lkey;
        gen_code = EV_NONE;
        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (press) begin
            gen_code = cur_code;
            lkey_n   = cur_code;
            cnt_n    = '0;
            case (cur_code)
                EV_LEFT, EV_RIGHT: state_n = DELAY;
                EV_SOFT:           state_n = REPEAT;
                default:           state_n = IDLE;
            endcase
        end else if (state != IDLE && cur_code != lkey) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                DELAY: if (frame_tick) begin
                    if (cnt == DAS_LAST) begin
                        gen_code = lkey;
                        state_n  = REPEAT;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                REPEAT: if (frame_tick) begin
                    if (cnt == period_last) begin
                        gen_code = lkey;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-deep holding register: load when empty or being accepted, else drop.
    always_ff @(posedge Clk) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_code  <= EV_NONE;
            evt_drop  <= 1'b0;
        end else begin
            evt_drop <= 1'b0;
            if (gen_code != EV_NONE) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_code  <= gen_code;
                end else begin
                    evt_drop <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule
